b06_intr_ctrl_mc: RTL

Parametrised multi-channel successor to the single-channel b06 interrupt-handshake controller.
- Arbitrates NCH request lines (EQL) under a per-channel mask and selects one channel (fixed or round-robin priority).
- Drives the CC_MUX select and enables the external counter.
- Waits for CONT_EQL, acknowledges, then waits for the request to drop.
- Adds a watchdog timeout, a sticky error flag and a wrapping serviced-interrupt counter.
- Sits between peripheral request lines and the shared compare counter.

---
 rtl/b06_intr_ctrl_mc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/b06_intr_ctrl_mc.sv
// Multi-channel interrupt handshake controller: arbitrates masked request lines, steers the
// shared compare counter through CC_MUX and runs the ack handshake under a watchdog.
module b06_intr_ctrl_mc #(
    parameter int NCH     = 4,
    parameter int IDX_W   = 2,
    parameter int TMO_W   = 4,
    parameter int TIMEOUT = 12,
    parameter int CNT_W   = 8,
    parameter bit RR_MODE = 1'b0
) (
    input  logic             clock,
    input  logic             nRESET_G,
    input  logic [NCH-1:0]   EQL,
    input  logic [NCH-1:0]   MASK,
    input  logic             CONT_EQL,
    input  logic             ERR_CLR,
    output logic [IDX_W:0]   CC_MUX,
    output logic [NCH-1:0]   USCITE,
    output logic             ENABLE_COUNT,
    output logic             ACKOUT,
    output logic             ERR_FLAG,
    output logic [CNT_W-1:0] SERVICED
);
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ENIN, S_INTR, S_INTR_W, S_ABORT} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, gnt_idx, idx_inc;
    logic [IDX_W:0]   idx_nx, cc_mux_q, cc_mux_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic [NCH-1:0]   uscite_q, uscite_d, req;
    logic             en_q, en_d, ack_q, ack_d, err_q, err_d, wd_expired;
    logic [CNT_W-1:0] srv_q, srv_d;

    // First set bit of r at or above base, wrapping modulo NCH.
    function automatic logic [IDX_W-1:0] pick(input logic [NCH-1:0] r, input logic [IDX_W-1:0] base);
        logic [IDX_W:0] j;
        logic           found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            j = {1'b0, base} + (IDX_W+1)'(k);
            if (j >= (IDX_W+1)'(NCH)) j = j - (IDX_W+1)'(NCH);
            if (!found && r[j[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = j[IDX_W-1:0];
            end
        end
    endfunction

    assign req        = EQL & ~MASK;
    assign wd_expired = (wd_q == TMO_W'(TIMEOUT - 1));
    assign gnt_idx    = pick(req, RR_MODE ? ptr_q : '0);
    assign idx_nx     = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign idx_inc    = (idx_nx == (IDX_W+1)'(NCH)) ? '0 : idx_nx[IDX_W-1:0];

    always_ff @(posedge clock or negedge nRESET_G) begin
        if (!nRESET_G) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (|req) state_d = S_ARB;
            S_ARB:    state_d = (|req) ? S_ENIN : S_IDLE;
            S_ENIN: begin
                if (CONT_EQL)        state_d = S_INTR;
                else if (wd_expired) state_d = S_ABORT;
            end
            S_INTR:   state_d = S_INTR_W;
            // Only the granted line releases the handshake; mask is not consulted here.
            S_INTR_W: if (!EQL[idx_q]) state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed for the state being entered.
    always_comb begin
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        wd_d     = wd_q;
        cc_mux_d = cc_mux_q;
        uscite_d = '0;
        en_d     = en_q;
        ack_d    = 1'b0;
        srv_d    = srv_q;
        err_d    = ERR_CLR ? 1'b0 : err_q;
        case (state_q)
            S_ARB: begin
                if (|req) begin
                    idx_d    = gnt_idx;
                    cc_mux_d = {1'b0, gnt_idx} + (IDX_W+1)'(1);
                    en_d     = 1'b1;
                    wd_d     = '0;
                end else begin
                    cc_mux_d = '0;
                end
            end
            S_ENIN: begin
                if (CONT_EQL) begin
                    en_d     = 1'b0;
                    uscite_d = NCH'(1'b1) << idx_q;
                    ack_d    = 1'b1;
                    srv_d    = srv_q + CNT_W'(1);
                    ptr_d    = idx_inc;
                    wd_d     = '0;
                end else if (wd_expired) begin
                    en_d     = 1'b0;
                    cc_mux_d = '0;
                    err_d    = 1'b1;
                    ptr_d    = idx_inc;
                    wd_d     = '0;
                end else begin
                    wd_d = wd_q + TMO_W'(1);
                end
            end
            S_INTR_W: if (!EQL[idx_q]) cc_mux_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge nRESET_G) begin
        if (!nRESET_G) begin
            idx_q    <= '0;
            ptr_q    <= '0;
            wd_q     <= '0;
            cc_mux_q <= '0;
            uscite_q <= '0;
            en_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            srv_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            wd_q     <= wd_d;
            cc_mux_q <= cc_mux_d;
            uscite_q <= uscite_d;
            en_q     <= en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            srv_q    <= srv_d;
        end
    end

    assign CC_MUX       = cc_mux_q;
    assign USCITE       = uscite_q;
    assign ENABLE_COUNT = en_q;
    assign ACKOUT       = ack_q;
    assign ERR_FLAG     = err_q;
    assign SERVICED     = srv_q;
endmodule
